tinyproc_loader: RTL

Serial boot loader that sits directly upstream of the tiny accumulator processor. It receives a program image over a single-wire 8N1 serial line, assembles 11-bit instruction words, and drives the processor's program-memory write port. It releases the processor via `cpu_run` once the full image is written. A framing error aborts the load and holds the processor stopped until reset.

---
 rtl/tinyproc_pkg.sv | 18 +
 rtl/serial_rx.sv | 101 ++++++++++
 rtl/tinyproc_loader.sv | 97 +++++++++
 3 files changed

// File: rtl/tinyproc_pkg.sv
// Shared definitions for the tiny accumulator processor boot loader.
//   INSTR_W  : width of one program-memory instruction word
//   PADDR_W  : width of the program-memory write address
//   load_state_t : loader FSM states
package tinyproc_pkg;

  localparam int INSTR_W = 11;
  localparam int PADDR_W = 8;

  typedef enum logic [2:0] {
    LD_COUNT = 3'd0,  // waiting for the word-count byte
    LD_LOW   = 3'd1,  // waiting for the low byte of a word
    LD_HIGH  = 3'd2,  // waiting for the high byte of a word
    LD_DONE  = 3'd3,  // image written, processor released
    LD_ERROR = 3'd4   // framing error seen, locked until reset
  } load_state_t;

endpackage

// File: rtl/serial_rx.sv
// 8N1 serial byte receiver.
// Ports:
//   clk        : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   rx         : asynchronous serial input, idles high
//   byte_valid : one-cycle pulse, data holds a received byte
//   byte_err   : one-cycle pulse, the frame had a low stop bit
//   data       : last received byte
module serial_rx
  import tinyproc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic       byte_err,
  output logic [7:0] data
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             rx_meta;
  logic             rx_s;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= RX_START;
        end
        RX_START: begin
          // Re-sample at mid start bit; a high line here was a glitch.
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};  // LSB arrives first
            if (bit_idx == 3'd7) state <= RX_STOP;
            bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin  // RX_STOP
          if (cnt == FULL_LAST) begin
            cnt        <= '0;
            byte_valid <= rx_s;
            byte_err   <= !rx_s;
            state      <= RX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign data = shreg;

endmodule

// File: rtl/tinyproc_loader.sv
// Serial boot loader for the tiny accumulator processor.
// Receives a count byte then (low, high) byte pairs over 8N1 serial, writes
// each assembled 11-bit word to program memory and releases the processor
// when the whole image is written. A framing error locks the loader until
// reset with the processor held stopped.
// Ports:
//   clk         : system clock, rising edge
//   reset_n     : asynchronous active-low reset
//   rx          : serial input, idles high
//   prog_we     : one-cycle program-memory write strobe
//   prog_addr   : write address (instruction index)
//   prog_data   : instruction word, [10:8] opcode, [7:0] operand
//   cpu_run     : high once the load completes
//   frame_error : sticky, set on a bad stop bit during the load
module tinyproc_loader
  import tinyproc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               rx,
  output logic               prog_we,
  output logic [PADDR_W-1:0] prog_addr,
  output logic [INSTR_W-1:0] prog_data,
  output logic               cpu_run,
  output logic               frame_error
);

  logic        byte_valid;
  logic        byte_err;
  logic [7:0]  rx_byte;

  load_state_t        state;
  logic [8:0]         remaining;  // 9 bits so a count of 256 fits
  logic [PADDR_W-1:0] index;
  logic [7:0]         low_byte;

  serial_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .byte_valid(byte_valid),
    .byte_err  (byte_err),
    .data      (rx_byte)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= LD_COUNT;
      remaining   <= '0;
      index       <= '0;
      low_byte    <= '0;
      prog_we     <= 1'b0;
      prog_addr   <= '0;
      prog_data   <= '0;
      cpu_run     <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      prog_we <= 1'b0;
      case (state)
        LD_COUNT, LD_LOW, LD_HIGH: begin
          if (byte_err) begin
            state       <= LD_ERROR;
            frame_error <= 1'b1;
          end else if (byte_valid) begin
            if (state == LD_COUNT) begin
              remaining <= (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
              state     <= LD_LOW;
            end else if (state == LD_LOW) begin
              low_byte <= rx_byte;
              state    <= LD_HIGH;
            end else begin
              prog_we   <= 1'b1;
              prog_addr <= index;
              prog_data <= {rx_byte[2:0], low_byte};
              index     <= index + 1'b1;
              remaining <= remaining - 1'b1;
              // Last word: release the processor on the same edge as its write.
              if (remaining == 9'd1) begin
                state   <= LD_DONE;
                cpu_run <= 1'b1;
              end else begin
                state <= LD_LOW;
              end
            end
          end
        end
        LD_DONE:  state <= LD_DONE;
        default:  state <= LD_ERROR;
      endcase
    end
  end

endmodule
